// File: rtl/mod_n_pkg.sv
// mod_n_pkg: shared constants and types for the mod_n modular-reduction unit.
//   A_WIDTH    : default dividend width
//   B_WIDTH    : default modulus / result width
//   ITERATIONS : shift/subtract iterations per operation (one per dividend bit)
//   state_e    : controller states
package mod_n_pkg;

  localparam int A_WIDTH    = 16;
  localparam int B_WIDTH    = 8;
  localparam int ITERATIONS = A_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_n_step.sv
// mod_n_step: one combinational restoring-division iteration.
// Ports:
//   r_i   : current partial remainder (always < modulus, so B_WIDTH bits suffice)
//   bit_i : next dividend bit, shifted in at the LSB
//   bq_i  : latched modulus
//   r_o   : new partial remainder, B_WIDTH+1 bits wide
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int B_WIDTH = mod_n_pkg::B_WIDTH
) (
  input  logic [B_WIDTH-1:0] r_i,
  input  logic               bit_i,
  input  logic [B_WIDTH-1:0] bq_i,
  output logic [B_WIDTH:0]   r_o
);

  logic [B_WIDTH:0] r_shift_s;
  logic [B_WIDTH:0] bq_ext_s;

  assign r_shift_s = {r_i, bit_i};
  assign bq_ext_s  = {1'b0, bq_i};

  // Shift in the next bit, then subtract the modulus if it fits (restoring step).
  always_comb begin
    r_o = r_shift_s;
    if (r_shift_s >= bq_ext_s) begin
      r_o = r_shift_s - bq_ext_s;
    end else begin
      r_o = r_shift_s;
    end
  end

endmodule

// File: rtl/mod_n.sv
// mod_n: sequential x = a mod b, one dividend bit per clock.
// Ports:
//   x      : result a mod b (0 when b == 0), valid while ready is high
//   ready  : result valid; held until reset
//   a      : dividend, latched on the load edge
//   b      : modulus, latched on the load edge
//   clock  : rising-edge clock
//   enable : level-sensitive start request, honoured only in IDLE
//   reset  : asynchronous active-high reset, aborts any operation
// Latency: ready and x are valid after the 16th edge following the load edge.
module mod_n
  import mod_n_pkg::*;
#(
  parameter int A_WIDTH = mod_n_pkg::A_WIDTH,
  parameter int B_WIDTH = mod_n_pkg::B_WIDTH
) (
  output logic [B_WIDTH-1:0] x,
  output logic               ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               clock,
  input  logic               enable,
  input  logic               reset
);

  localparam int CNT_WIDTH = $clog2(A_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(A_WIDTH - 1);

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   dvd_q, dvd_d;
  logic [B_WIDTH:0]     r_q, r_d;
  logic [B_WIDTH-1:0]   bq_q, bq_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [B_WIDTH-1:0]   x_q, x_d;
  logic                 ready_q, ready_d;

  logic [B_WIDTH:0]     step_r_s;
  logic                 unused_r_msb_s;

  // The remainder is always below the modulus after a step, so its MSB never
  // feeds the next iteration.
  assign unused_r_msb_s = r_q[B_WIDTH];

  mod_n_step #(
    .B_WIDTH(B_WIDTH)
  ) u_step (
    .r_i  (r_q[B_WIDTH-1:0]),
    .bit_i(dvd_q[A_WIDTH-1]),
    .bq_i (bq_q),
    .r_o  (step_r_s)
  );

  // Controller next-state and datapath update.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    r_d     = r_q;
    bq_d    = bq_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = BUSY;
          dvd_d   = a;
          bq_d    = b;
          r_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        dvd_d = {dvd_q[A_WIDTH-2:0], 1'b0};
        r_d   = step_r_s;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          ready_d = 1'b1;
          // With a zero modulus every step subtracts nothing, leaving the low
          // dividend bits in r; the defined result for b == 0 is zero.
          if (bq_q == '0) begin
            x_d = '0;
          end else begin
            x_d = step_r_s[B_WIDTH-1:0];
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      r_q     <= '0;
      bq_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      r_q     <= r_d;
      bq_q    <= bq_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      ready_q <= ready_d;
    end
  end

  assign x     = x_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_mod_n.sv
// tb_mod_n: scoreboard bench for mod_n. Stimulus pushes the reference result
// (a mod b, or 0 for b == 0) into a queue; a monitor pops it when ready rises
// and also checks latency and that x holds while ready stays high.
module tb_mod_n;

  localparam int LAT = 16;

  logic [7:0]  x;
  logic        ready;
  logic [15:0] a;
  logic [7:0]  b;
  logic        clock;
  logic        enable;
  logic        reset;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          load_cyc = 0;
  logic [7:0]  exp_q[$];

  mod_n dut (
    .x     (x),
    .ready (ready),
    .a     (a),
    .b     (b),
    .clock (clock),
    .enable(enable),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] ref_mod(input int unsigned av, input int unsigned bv);
    if (bv == 0) return 8'h00;
    return 8'(av % bv);
  endfunction

  // Monitor: compare on ready rising, then check x holds while ready stays high.
  initial begin : monitor
    logic       in_ready;
    logic [7:0] cur_x;
    logic [7:0] e;
    int         lat;
    in_ready = 1'b0;
    cur_x    = 8'h00;
    forever begin
      @(negedge clock);
      if (ready === 1'b1) begin
        if (!in_ready) begin
          in_ready = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: ready=1 with no operation pending (x=%0d)", x);
          end else begin
            e     = exp_q.pop_front();
            cur_x = e;
            if (x !== e) begin
              errors++;
              $display("FAIL result: x=%0d expected %0d", x, e);
            end
            checks++;
            lat = cyc - load_cyc;
            if (lat != LAT) begin
              errors++;
              $display("FAIL latency: ready after %0d clocks expected %0d", lat, LAT);
            end
          end
        end else begin
          checks++;
          if (x !== cur_x) begin
            errors++;
            $display("FAIL x_hold: x=%0d while ready, expected %0d", x, cur_x);
          end
        end
      end else begin
        in_ready = 1'b0;
      end
    end
  end

  // Assert reset for 10 time units between clock edges; outputs must clear without an edge.
  task automatic do_reset(input logic en, input logic [15:0] av, input logic [7:0] bv);
    @(negedge clock);
    #1;
    reset  = 1'b1;
    enable = en;
    a      = av;
    b      = bv;
    #1;
    checks++;
    if (ready !== 1'b0 || x !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: ready=%b x=%0d expected ready=0 x=0", ready, x);
    end
    #9;
    reset = 1'b0;
  endtask

  // mode 0: normal; mode 1: enable held high through reset release; mode 2: abort mid-BUSY.
  task automatic run_op(input logic [15:0] av, input logic [7:0] bv, input int mode);
    do_reset(mode == 1, av, bv);
    exp_q.push_back(ref_mod(av, bv));
    a      = av;
    b      = bv;
    enable = 1'b1;
    @(negedge clock);
    load_cyc = cyc;
    a      = 16'($urandom);
    b      = 8'($urandom);
    enable = 1'($urandom_range(0, 1));
    if (mode == 2) begin
      repeat (7) @(negedge clock);
      exp_q.delete();
      do_reset(1'b0, 16'h0000, 8'h00);
      repeat (20) @(negedge clock);
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ready: ready=%b expected 0", ready);
      end
      return;
    end
    for (int i = 0; i < 40 && ready !== 1'b1; i++) @(negedge clock);
    if (ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL timeout: ready=%b expected 1 within 40 clocks", ready);
      exp_q.delete();
    end
    // Enable and operand changes in DONE must not disturb x.
    enable = 1'b1;
    a      = 16'($urandom);
    b      = 8'($urandom);
    repeat (3) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    a      = 16'h0000;
    b      = 8'h00;
    do_reset(1'b0, 16'h0000, 8'h00);
    repeat (3) @(negedge clock);
    checks++;
    if (ready !== 1'b0 || x !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b x=%0d expected ready=0 x=0", ready, x);
    end

    run_op(16'd241,   8'd32,  0);
    run_op(16'd241,   8'd27,  0);
    run_op(16'd65535, 8'd255, 0);
    run_op(16'd65535, 8'd254, 0);
    run_op(16'd5,     8'd200, 0);
    run_op(16'd1234,  8'd0,   0);
    run_op(16'd1234,  8'd0,   2);
    run_op(16'd50000, 8'd77,  0);
    run_op(16'd300,   8'd1,   1);
    run_op(16'd65535, 8'd1,   0);
    run_op(16'd0,     8'd9,   0);
    for (int k = 0; k < 20; k++) begin
      run_op(16'($urandom), 8'($urandom_range(0, 255)), (k % 5 == 0) ? 1 : 0);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d results never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
